logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the two-input gate set.
- Applies one of eight bitwise operations to WIDTH-bit operands selected per transaction: AND, OR, XOR, XNOR, NAND, NOR, NOT, and an accumulating XOR.
- Valid/ready handshakes on both sides, a fixed two-stage pipeline, zero and parity flags.
- Sits between a stimulus/control source and any consumer of bitwise results; full throughput of one transaction per cycle.

---
 rtl/logic_unit_pkg.sv | 19 +
 rtl/logic_unit_core.sv | 39 +++
 rtl/logic_unit_pipe.sv | 111 +++++++++++
 tb/tb_logic_unit_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: the operation
// encoding used on in_op and carried through stage 1.
package logic_unit_pkg;

    localparam int OP_W = 3;

    // Operation codes; the enum doubles as the op type and the OP_* constants.
    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_XNOR = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_NOT  = 3'd6,
        OP_ACC  = 3'd7
    } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational datapath between stage 1 and stage 2: evaluates the selected
// bitwise operation and derives the zero and parity flags of the result.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    // Operation select; b is unused by NOT and ACC, acc only by ACC.
    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_NOT:  result = ~a;
            OP_ACC:  result = acc ^ a;
            default: result = '0;
        endcase
    end

    // Flags are computed here so stage 2 can register them alongside result.
    always_comb begin
        zero   = (result == '0);
        parity = ^result;
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides and
// an internal XOR accumulator updated when an ACC result enters stage 2.
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// source never withdraws valid or changes its payload before the transfer;
// ready may be asserted independently of valid. Here in_ready depends only
// on pipeline state and out_ready, never on in_valid.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity
);

    // Stage 1: captured operands.
    logic             s1_v;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Stage 2: registered result and flags.
    logic             s2_v;
    logic [WIDTH-1:0] s2_data;
    logic             s2_zero;
    logic             s2_parity;

    logic [WIDTH-1:0] acc;

    // Core outputs for the S1 -> S2 transfer.
    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_parity;

    logic s2_adv;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .acc    (acc),
        .result (core_result),
        .zero   (core_zero),
        .parity (core_parity)
    );

    // Advance conditions: the only combinational path is out_ready -> in_ready.
    always_comb begin
        s2_adv   = !s2_v || out_ready;
        in_ready = !s1_v || s2_adv;
    end

    // Stage 1 register: loads whenever it is empty or draining into stage 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_op <= OP_AND;
            s1_a  <= '0;
            s1_b  <= '0;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_op <= op_e'(in_op);
                s1_a  <= in_a;
                s1_b  <= in_b;
            end
        end
    end

    // Stage 2 register and accumulator: acc moves on the same edge the ACC
    // result enters stage 2, so back-to-back ACC ops see each other's update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v      <= 1'b0;
            s2_data   <= '0;
            s2_zero   <= 1'b1;
            s2_parity <= 1'b0;
            acc       <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_data   <= core_result;
                s2_zero   <= core_zero;
                s2_parity <= core_parity;
                if (s1_op == OP_ACC) begin
                    acc <= core_result;
                end
            end
        end
    end

    // Outputs come straight from stage 2 so they hold while stalled.
    always_comb begin
        out_valid  = s2_v;
        out_data   = s2_data;
        out_zero   = s2_zero;
        out_parity = s2_parity;
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe (WIDTH=8): directed scenarios then a randomized
// handshake run, scored against an expected-result queue fed by a
// transaction-level model of the operation table and accumulator.
module tb_logic_unit_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_zero;
    logic         out_parity;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] const_q[$];
    int           tq[$];
    logic [W-1:0] model_acc;
    logic         lat_chk;
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_zero;
    logic         prev_parity;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_parity (out_parity)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the operation table applied at transaction level.
    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] acc_v);
        logic [W-1:0] r;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a ^ b);
            3'd4: r = ~(a & b);
            3'd5: r = ~(a | b);
            3'd6: r = ~a;
            default: r = acc_v ^ a;
        endcase
        return r;
    endfunction

    // Driver + scoreboard for one clock cycle. Inputs change just after the
    // falling edge; outputs and handshakes are sampled before the rising edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy,
                        output logic accepted, output logic rdy);
        logic [W-1:0] e;
        logic [W-1:0] m;
        int t;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        rdy = in_ready;
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
            chk("stall_zero", 32'(out_zero), 32'(prev_zero));
            chk("stall_parity", 32'(out_parity), 32'(prev_parity));
        end
        accepted = v && in_ready;
        if (out_valid && out_ready) begin
            chk("emit_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tq.pop_front();
                chk("out_data", 32'(out_data), 32'(e));
                chk("out_zero", 32'(out_zero), 32'(e == '0));
                chk("out_parity", 32'(out_parity), 32'(^e));
                if (lat_chk) chk("latency", 32'(cyc - t), 32'd2);
            end
        end
        if (accepted) begin
            m = ref_op(op, a, b, model_acc);
            if (op == 3'd7) model_acc = m;
            if (const_q.size() != 0) exp_q.push_back(const_q.pop_front());
            else exp_q.push_back(m);
            tq.push_back(cyc);
        end
        prev_stall  = out_valid && !out_ready;
        prev_data   = out_data;
        prev_zero   = out_zero;
        prev_parity = out_parity;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        exp_q.delete();
        tq.delete();
        model_acc  = '0;
        prev_stall = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        chk("rst_out_parity", 32'(out_parity), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic drain();
        logic acc_o, rdy_o;
        int guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            step(1'b0, 3'd0, '0, '0, 1'b1, acc_o, rdy_o);
            guard++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic acc_o, rdy_o;
        logic [W-1:0] gate_exp [7];
        logic [2:0] bp_op [4];
        logic [W-1:0] bp_a [4];
        int n;
        int tries;

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        model_acc = '0; lat_chk = 1'b0; prev_stall = 1'b0;
        prev_data = '0; prev_zero = 1'b0; prev_parity = 1'b0;
        @(negedge clk);

        // Reset state.
        do_reset();

        // Gate sweep: a=F0, b=3C, ops 0..6, expected values from the test table.
        gate_exp = '{8'h30, 8'hFC, 8'hCC, 8'h33, 8'hCF, 8'h03, 8'h0F};
        for (int i = 0; i < 7; i++) const_q.push_back(gate_exp[i]);
        lat_chk = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 3'(i), 8'hF0, 8'h3C, 1'b1, acc_o, rdy_o);
            chk("sweep_accept", 32'(acc_o), 32'd1);
        end
        drain();
        lat_chk = 1'b0;

        // Accumulate: ACC 55, FF, AA then NOT 00.
        do_reset();
        const_q.push_back(8'h55); const_q.push_back(8'hAA);
        const_q.push_back(8'h00); const_q.push_back(8'hFF);
        step(1'b1, 3'd7, 8'h55, 8'h00, 1'b1, acc_o, rdy_o);
        step(1'b1, 3'd7, 8'hFF, 8'h00, 1'b1, acc_o, rdy_o);
        step(1'b1, 3'd7, 8'hAA, 8'h00, 1'b1, acc_o, rdy_o);
        step(1'b1, 3'd6, 8'h00, 8'h00, 1'b1, acc_o, rdy_o);
        drain();

        // Backpressure: four ops with out_ready low, then release.
        bp_op = '{3'd0, 3'd1, 3'd7, 3'd2};
        bp_a  = '{8'hA5, 8'h18, 8'h3C, 8'hE7};
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bp_op[n], bp_a[n], 8'h5A, 1'b0, acc_o, rdy_o);
            chk("bp_in_ready", 32'(rdy_o), 32'(i < 2));
            if (acc_o) n++;
        end
        tries = 0;
        while (n < 4 && tries < 20) begin
            step(1'b1, bp_op[n], bp_a[n], 8'h5A, 1'b1, acc_o, rdy_o);
            if (acc_o) n++;
            tries++;
        end
        chk("bp_all_accepted", 32'(n), 32'd4);
        drain();

        // Reset mid-stream with both stages full.
        do_reset();
        step(1'b1, 3'd7, 8'h0F, 8'h00, 1'b0, acc_o, rdy_o);
        step(1'b1, 3'd7, 8'h0F, 8'h00, 1'b0, acc_o, rdy_o);
        chk("mid_full_in_ready", 32'(in_ready), 32'd0);
        do_reset();
        const_q.push_back(8'h01);
        step(1'b1, 3'd7, 8'h01, 8'h00, 1'b1, acc_o, rdy_o);
        drain();

        // Random handshake: 1000 transactions.
        n = 0;
        tries = 0;
        while (n < 1000 && tries < 20000) begin
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), W'($urandom),
                 W'($urandom), ($urandom_range(0, 9) < 7), acc_o, rdy_o);
            if (acc_o) n++;
            tries++;
        end
        chk("rand_count", 32'(n), 32'd1000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
